// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU select encodings (3 bits, 101..111 left undefined)
//   - arbiter FSM state encoding
//   - default settle times and counter width
//   - packed operation record carried from a requester to the shared ALU
package alu_pkg;

    typedef enum logic [2:0] {
        SEL_ADD = 3'b000,
        SEL_SUB = 3'b001,
        SEL_AND = 3'b010,
        SEL_OR  = 3'b011,
        SEL_FWD = 3'b100
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int DEF_SETTLE_ARITH = 2;
    localparam int DEF_SETTLE_LOGIC = 1;
    localparam int CNT_W            = 16;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  sel;
    } alu_op_t;

    // ADD/SUB go through the carry chain and need the longer settle time.
    function automatic logic is_arith(input logic [2:0] sel);
        return (sel == SEL_ADD) || (sel == SEL_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter, the shared ALU and the
// response consumer.
//   slave  : arbiter side (takes requests, drives ALU operands and response)
//   master : environment side (requesters, ALU, response consumer)
interface alu_arbiter_if;

    logic        REQ0_VALID, REQ1_VALID;
    logic        REQ0_READY, REQ1_READY;
    logic [31:0] REQ0_DATA1, REQ0_DATA2, REQ1_DATA1, REQ1_DATA2;
    logic [2:0]  REQ0_SELECT, REQ1_SELECT;
    logic [31:0] ALU_DATA1, ALU_DATA2;
    logic [2:0]  ALU_SELECT;
    logic [31:0] ALU_RESULT;
    logic        RSP_VALID, RSP_READY, RSP_ID;
    logic [31:0] RSP_RESULT;
    logic        BUSY;

    modport slave (
        input  REQ0_VALID, REQ1_VALID,
        input  REQ0_DATA1, REQ0_DATA2, REQ1_DATA1, REQ1_DATA2,
        input  REQ0_SELECT, REQ1_SELECT,
        input  ALU_RESULT, RSP_READY,
        output REQ0_READY, REQ1_READY,
        output ALU_DATA1, ALU_DATA2, ALU_SELECT,
        output RSP_VALID, RSP_ID, RSP_RESULT, BUSY
    );

    modport master (
        output REQ0_VALID, REQ1_VALID,
        output REQ0_DATA1, REQ0_DATA2, REQ1_DATA1, REQ1_DATA2,
        output REQ0_SELECT, REQ1_SELECT,
        output ALU_RESULT, RSP_READY,
        input  REQ0_READY, REQ1_READY,
        input  ALU_DATA1, ALU_DATA2, ALU_SELECT,
        input  RSP_VALID, RSP_ID, RSP_RESULT, BUSY
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational.
//   req_i      : request vector, bit n = requester n
//   last_gnt_i : index of the requester granted most recently
//   gnt_o      : one-hot grant (all zero when nothing requests)
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        // Contention: the one not served last time wins.
        if (&req_i) gnt_o = last_gnt_i ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared, multi-cycle ALU.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus          : requester handshakes, registered ALU operands/select,
//                  ALU result input, response handshake, BUSY
// IDLE grants one requester (round robin) and latches its operation; EXEC
// waits the settle time of that select; RESP holds the captured result
// until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int SETTLE_ARITH = DEF_SETTLE_ARITH,
    parameter int SETTLE_LOGIC = DEF_SETTLE_LOGIC
) (
    input  logic         CLK,
    input  logic         RESET_N,
    alu_arbiter_if.slave bus
);

    // A zero or negative settle time would never reach the capture count.
    localparam int              SA      = (SETTLE_ARITH < 1) ? 1 : SETTLE_ARITH;
    localparam int              SL      = (SETTLE_LOGIC < 1) ? 1 : SETTLE_LOGIC;
    localparam logic [CNT_W-1:0] N_ARITH = SA[CNT_W-1:0];
    localparam logic [CNT_W-1:0] N_LOGIC = SL[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             id_q;
    alu_op_t          op_q;
    logic             rsp_valid_q, rsp_id_q;
    logic [31:0]      rsp_result_q;

    logic [1:0]       req, gnt, ready;
    logic             xfer;
    alu_op_t          op_d;
    logic [CNT_W-1:0] settle_d;

    assign req = {bus.REQ1_VALID, bus.REQ0_VALID};

    rr_arbiter2 u_rr (
        .req_i      (req),
        .last_gnt_i (last_q),
        .gnt_o      (gnt)
    );

    // READY is combinational from the registered state; held low while in
    // reset so nothing is offered before the block is running.
    assign ready          = gnt & {2{(state_q == ST_IDLE) && RESET_N}};
    assign xfer           = |ready;
    assign bus.REQ0_READY = ready[0];
    assign bus.REQ1_READY = ready[1];

    always_comb begin
        op_d = ready[1] ? '{d1: bus.REQ1_DATA1, d2: bus.REQ1_DATA2, sel: bus.REQ1_SELECT}
                        : '{d1: bus.REQ0_DATA1, d2: bus.REQ0_DATA2, sel: bus.REQ0_SELECT};
        settle_d = is_arith(op_d.sel) ? N_ARITH : N_LOGIC;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_q       <= 1'b1;      // requester 0 wins the first contention
            id_q         <= 1'b0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        op_q    <= op_d;
                        id_q    <= ready[1];
                        last_q  <= ready[1];
                        cnt_q   <= settle_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        rsp_result_q <= bus.ALU_RESULT;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // No grant on this edge: IDLE is entered first.
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ALU_DATA1  = op_q.d1;
    assign bus.ALU_DATA2  = op_q.d2;
    assign bus.ALU_SELECT = op_q.sel;
    assign bus.RSP_VALID  = rsp_valid_q;
    assign bus.RSP_ID     = rsp_id_q;
    assign bus.RSP_RESULT = rsp_result_q;
    assign bus.BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter #(.SETTLE_ARITH(2), .SETTLE_LOGIC(1)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    // Shared ALU stand-in; undefined selects return 0.
    always_comb begin
        bus.ALU_RESULT = '0;
        case (bus.ALU_SELECT)
            3'b000: bus.ALU_RESULT = bus.ALU_DATA1 + bus.ALU_DATA2;
            3'b001: bus.ALU_RESULT = bus.ALU_DATA1 - bus.ALU_DATA2;
            3'b010: bus.ALU_RESULT = bus.ALU_DATA1 & bus.ALU_DATA2;
            3'b011: bus.ALU_RESULT = bus.ALU_DATA1 | bus.ALU_DATA2;
            3'b100: bus.ALU_RESULT = bus.ALU_DATA1;
            default: bus.ALU_RESULT = '0;
        endcase
    end

    typedef struct {
        logic        v0, v1;
        logic [2:0]  s0, s1;
        logic [31:0] a0, b0, a1, b1;
        logic        exp_id;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Counts edges after the transfer edge until RSP_VALID is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (bus.RSP_VALID !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_rsp();
        bus.RSP_READY = 1'b1;
        @(posedge clk); #1;
        bus.RSP_READY = 1'b0;
        chk("rsp_valid_clear", bus.RSP_VALID, 0);
        chk("busy_after_rsp", bus.BUSY, 0);
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int lat;
        int k;
        @(negedge clk);
        bus.REQ0_VALID = v.v0; bus.REQ0_SELECT = v.s0; bus.REQ0_DATA1 = v.a0; bus.REQ0_DATA2 = v.b0;
        bus.REQ1_VALID = v.v1; bus.REQ1_SELECT = v.s1; bus.REQ1_DATA1 = v.a1; bus.REQ1_DATA2 = v.b1;
        #1;
        k = 0;
        while (!(bus.REQ0_READY || bus.REQ1_READY) && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        chk($sformatf("row%0d_ready", idx), {bus.REQ1_READY, bus.REQ0_READY}, v.exp_id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        chk($sformatf("row%0d_busy", idx), bus.BUSY, 1);
        chk($sformatf("row%0d_alu_sel", idx), bus.ALU_SELECT, v.exp_id ? v.s1 : v.s0);
        wait_rsp(lat);
        chk($sformatf("row%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("row%0d_result", idx), bus.RSP_RESULT, v.exp_res);
        chk($sformatf("row%0d_id", idx), bus.RSP_ID, v.exp_id);
        take_rsp();
        // Operands stay on the ALU bus through IDLE.
        chk($sformatf("row%0d_alu_d1_hold", idx), bus.ALU_DATA1, v.exp_id ? v.a1 : v.a0);
    endtask

    initial begin
        int lat;
        vec_t v;

        // Round-robin rows come first, right out of reset.
        tbl[0] = '{1, 1, 3'b010, 3'b001, 32'hF0, 32'h3C, 32'd10, 32'd3, 1'b0, 32'h30, 1};
        tbl[1] = '{1, 1, 3'b010, 3'b001, 32'hF0, 32'h3C, 32'd10, 32'd3, 1'b1, 32'd7, 2};
        tbl[2] = '{1, 1, 3'b010, 3'b001, 32'hF0, 32'h3C, 32'd10, 32'd3, 1'b0, 32'h30, 1};
        tbl[3] = '{1, 0, 3'b000, 3'b000, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 32'd12, 2};
        tbl[4] = '{0, 1, 3'b000, 3'b111, 32'd0, 32'd0, 32'd7, 32'd9, 1'b1, 32'd0, 1};
        tbl[5] = '{1, 0, 3'b001, 3'b000, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 2};
        tbl[6] = '{1, 0, 3'b011, 3'b000, 32'hA0, 32'h0B, 32'd0, 32'd0, 1'b0, 32'hAB, 1};
        tbl[7] = '{0, 1, 3'b000, 3'b100, 32'd0, 32'd0, 32'h12345678, 32'd5, 1'b1, 32'h12345678, 1};
        tbl[8] = '{1, 1, 3'b000, 3'b011, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd2, 1'b0, 32'd1, 2};
        tbl[9] = '{0, 1, 3'b000, 3'b101, 32'd0, 32'd0, 32'h55, 32'h66, 1'b1, 32'd0, 1};

        bus.REQ0_VALID = 1'b1; bus.REQ1_VALID = 1'b1;
        bus.REQ0_DATA1 = '0; bus.REQ0_DATA2 = '0; bus.REQ0_SELECT = '0;
        bus.REQ1_DATA1 = '0; bus.REQ1_DATA2 = '0; bus.REQ1_SELECT = '0;
        bus.RSP_READY = 1'b0;

        // Reset state, with both requesters valid: nothing may be offered.
        #12;
        chk("rst_ready", {bus.REQ1_READY, bus.REQ0_READY}, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_rsp_valid", bus.RSP_VALID, 0);
        chk("rst_alu_d1", bus.ALU_DATA1, 0);
        chk("rst_rsp_result", bus.RSP_RESULT, 0);
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_row(i, tbl[i]);

        // Consumer stalls 5 cycles while both requesters wait.
        @(negedge clk);
        bus.REQ0_VALID = 1'b1; bus.REQ0_SELECT = 3'b000; bus.REQ0_DATA1 = 32'd1; bus.REQ0_DATA2 = 32'd2;
        @(posedge clk); #1;
        bus.REQ0_VALID = 1'b0;
        wait_rsp(lat);
        chk("stall_latency", lat, 2);
        bus.REQ0_VALID = 1'b1; bus.REQ1_VALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_rsp_valid", bus.RSP_VALID, 1);
            chk("stall_rsp_result", bus.RSP_RESULT, 32'd3);
            chk("stall_ready", {bus.REQ1_READY, bus.REQ0_READY}, 0);
            chk("stall_busy", bus.BUSY, 1);
        end
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        take_rsp();

        // Reset in the middle of an ADD: operation is dropped.
        @(negedge clk);
        bus.REQ0_VALID = 1'b1; bus.REQ0_SELECT = 3'b000; bus.REQ0_DATA1 = 32'd5; bus.REQ0_DATA2 = 32'd7;
        @(posedge clk); #1;
        bus.REQ0_VALID = 1'b0;
        @(posedge clk); #1;
        chk("mid_exec_busy", bus.BUSY, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.BUSY, 0);
        chk("mid_rst_alu_d1", bus.ALU_DATA1, 0);
        chk("mid_rst_alu_d2", bus.ALU_DATA2, 0);
        chk("mid_rst_alu_sel", bus.ALU_SELECT, 0);
        chk("mid_rst_rsp", {bus.RSP_VALID, bus.RSP_ID}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", bus.RSP_VALID, 0);
        end
        v = '{1, 0, 3'b100, 3'b000, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 1'b0, 32'hDEADBEEF, 1};
        run_row(NV, v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
